// File: rtl/serpent_subkey_bank.sv
// Two-bank store for the 33 Serpent round subkeys: captures the key schedule's
// output, commits a bank on a fresh key-valid rise, serves 1-cycle reads.
module serpent_subkey_bank #(
    parameter int NUM_SUBKEYS = 33,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 128
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_load_start,
    input  logic              i_load_bank,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_key_valid,
    output logic              o_busy,
    output logic [1:0]        o_bank_ready,
    output logic              o_load_err,
    input  logic              i_rd_en,
    input  logic              i_rd_bank,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SUBKEYS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_COMMIT} state_t;

    state_t                   state_q, state_d;
    logic                     bank_q, bank_d;
    logic [NUM_SUBKEYS-1:0]   mask_q, mask_d;
    logic [1:0]               ready_q, ready_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     kv_q;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]        rd_data_q, rd_data_d;
    logic                     kv_rise;
    logic                     wr_take;
    logic [DATA_W-1:0]        mem_q [2][NUM_SUBKEYS];

    assign kv_rise = i_key_valid & ~kv_q;

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        mask_d     = mask_q;
        ready_d    = ready_q;
        err_d      = err_q;
        wr_take    = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_load_start) begin
                    bank_d               = i_load_bank;
                    ready_d[i_load_bank] = 1'b0;
                    err_d                = 1'b0;
                    mask_d               = '0;
                    state_d              = ST_FILL;
                end
            end
            ST_FILL: begin
                // A restart takes priority over any write in the same cycle.
                if (i_load_start) begin
                    bank_d               = i_load_bank;
                    ready_d[i_load_bank] = 1'b0;
                    mask_d               = '0;
                end else begin
                    if (i_wr_en && (i_wr_addr <= LAST_ADDR)) begin
                        wr_take           = 1'b1;
                        mask_d[i_wr_addr] = 1'b1;
                    end
                    if (kv_rise) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (&mask_q) begin
                    ready_d[bank_q] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        // Uncommitted or out-of-range reads return zero so stale keys never leak.
        if (i_rd_en) begin
            if (ready_q[i_rd_bank] && (i_rd_addr <= LAST_ADDR)) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_q[i_rd_bank][i_rd_addr];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            bank_q     <= 1'b0;
            mask_q     <= '0;
            ready_q    <= 2'b00;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            kv_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            mask_q     <= mask_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            kv_q       <= i_key_valid;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_take) begin
            mem_q[bank_q][i_wr_addr] <= i_wr_data;
        end
    end

    assign o_busy       = busy_q;
    assign o_bank_ready = ready_q;
    assign o_load_err   = err_q;
    assign o_rd_data    = rd_data_q;
    assign o_rd_valid   = rd_valid_q;

endmodule
